pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as listed below.
- clk  in  1  system clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  leave IDLE and begin execution.
- ID_rs, ID_rt  in  5 each  source register numbers of the instruction in ID.
- ID_use_rs, ID_use_rt  in  1 each  ID instruction actually reads rs / rt.
- EX_valid  in  1  IDtoEX stage holds a valid instruction (its Out flag).
- EX_load  in  1  EX instruction is a load.
- EX_rd  in  5  EX instruction destination register.
- branch_taken  in  1  EX resolved a taken branch or jump this cycle.
- halt_req  in  1  ID holds a valid halt (syscall) instruction.
- resume  in  1  leave HALT.
- PC_EN  out  1  PC register write enable.
- IFID_EN  out  1  IFtoID enable.
- IFID_CLR  out  1  IFtoID synchronous clear.
- IDEX_CLR  out  1  IDtoEX synchronous clear (bubble insert).
- EXMEM_CLR  out  1  EXtoMEM synchronous clear.
- state  out  2  IDLE=0, RUN=1, HALT=2; 3 is unused.
- cycle_cnt  out  32  RUN cycles executed.
- stall_cnt  out  16  load-use stall cycles.
- flush_cnt  out  16  branch flush events.

Function
REQ-002 The block SHALL implement a 3-state FSM (IDLE, RUN, HALT) held in a registered state; all enable and clear outputs SHALL be combinational decodes of the registered state and the current inputs.
REQ-003 The block SHALL compute the load-use hazard as luh = EX_valid & EX_load & (EX_rd != 0) & ((ID_use_rs & ID_rs == EX_rd) | (ID_use_rt & ID_rt == EX_rd)).
REQ-004 In IDLE, the outputs SHALL be PC_EN=0, IFID_EN=0, IFID_CLR=1, IDEX_CLR=1, EXMEM_CLR=1.
REQ-005 In IDLE with start=1, the next state SHALL be RUN; start SHALL be ignored in RUN and HALT.
REQ-006 In RUN, the block SHALL evaluate events in priority order: branch_taken, then luh, then halt_req, then normal operation.
REQ-007 On a RUN branch (branch_taken=1), the outputs SHALL be PC_EN=1, IFID_EN=1, IFID_CLR=1, IDEX_CLR=1, EXMEM_CLR=0, and flush_cnt SHALL increment.
REQ-008 A branch SHALL suppress luh and halt_req in the same cycle; neither stall_cnt nor state SHALL change because of them.
REQ-009 On a RUN load-use hazard (luh=1, no branch), the outputs SHALL be PC_EN=0, IFID_EN=0, IFID_CLR=0, IDEX_CLR=1, EXMEM_CLR=0, and stall_cnt SHALL increment; the stall therefore lasts exactly 1 cycle per hazard.
REQ-010 On a RUN halt (halt_req=1, no branch, no luh), the outputs SHALL be PC_EN=0, IFID_EN=0, all clears 0, and the next state SHALL be HALT; the syscall itself SHALL advance into EX.
REQ-011 In RUN with no event, the outputs SHALL be PC_EN=1, IFID_EN=1, all clears 0.
REQ-012 In HALT, the outputs SHALL be PC_EN=0, IFID_EN=0, IDEX_CLR=1, IFID_CLR=0, EXMEM_CLR=0, so that downstream stages drain.
REQ-013 In HALT with resume=1, IFID_CLR SHALL be 1 in that cycle, PC_EN SHALL remain 0, and the next state SHALL be RUN; the first RUN cycle SHALL then fetch the instruction after the syscall.
REQ-014 In HALT, branch_taken, luh and halt_req SHALL be ignored.
REQ-015 cycle_cnt SHALL increment on every clock edge at which state==RUN and SHALL wrap modulo 2^32.
REQ-016 stall_cnt and flush_cnt SHALL saturate at 0xFFFF.
REQ-017 Encoding 3 of state SHALL behave as IDLE and SHALL transition to IDLE on the next edge.

Reset
REQ-018 While RST=1, the outputs SHALL take the IDLE values of REQ-004 regardless of the other inputs.
REQ-019 At the edge with RST=1, state SHALL become IDLE and cycle_cnt, stall_cnt and flush_cnt SHALL become 0.
REQ-020 RST SHALL take priority over start, resume and all hazard inputs, including when asserted mid-stall or mid-HALT.

Verification
REQ-021 Reset then run: RST 2 cycles, start pulse, 10 idle RUN cycles -> state=1, PC_EN=IFID_EN=1 each cycle, cycle_cnt=10, stall_cnt=flush_cnt=0.
REQ-022 Load-use: EX_valid=1, EX_load=1, EX_rd=5, ID_rs=5, ID_use_rs=1 for 1 cycle -> PC_EN=0, IFID_EN=0, IDEX_CLR=1 that cycle, stall_cnt=1; repeat with EX_rd=0 -> no stall.
REQ-023 Branch with hazard: branch_taken=1 together with luh and halt_req -> IFID_CLR=1, IDEX_CLR=1, PC_EN=1, flush_cnt=1, stall_cnt unchanged, state stays RUN.
REQ-024 Halt/resume: halt_req for 1 cycle -> state=2 next cycle with IDEX_CLR=1 and PC_EN=0 for 5 cycles; resume pulse -> IFID_CLR=1, PC_EN=0 that cycle, then state=1 and PC_EN=1.
REQ-025 Reset mid-HALT and saturation: RST in HALT -> state=0 and counters 0 next edge; with stall_cnt preset to 0xFFFF, one more hazard -> stall_cnt stays 0xFFFF.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: IDLE/RUN/HALT sequencer for a 5-stage pipeline.
// Decodes load-use stalls, branch flushes and syscall halts.
module pipeline_ctrl (
    input  logic        clk,
    input  logic        RST,
    input  logic        start,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_use_rs,
    input  logic        ID_use_rt,
    input  logic        EX_valid,
    input  logic        EX_load,
    input  logic [4:0]  EX_rd,
    input  logic        branch_taken,
    input  logic        halt_req,
    input  logic        resume,
    output logic        PC_EN,
    output logic        IFID_EN,
    output logic        IFID_CLR,
    output logic        IDEX_CLR,
    output logic        EXMEM_CLR,
    output logic [1:0]  state,
    output logic [31:0] cycle_cnt,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic       luh;
    logic       rs_hit;
    logic       rt_hit;
    logic [1:0] next_state;
    logic       inc_stall;
    logic       inc_flush;

    // Load in EX whose result is needed by the instruction in ID.
    always_comb begin
        rs_hit = ID_use_rs & (ID_rs == EX_rd);
        rt_hit = ID_use_rt & (ID_rt == EX_rd);
        luh    = EX_valid & EX_load & (EX_rd != 5'd0) & (rs_hit | rt_hit);
    end

    // Output and next-state decode; branch beats stall beats halt in RUN.
    always_comb begin
        PC_EN      = 1'b0;
        IFID_EN    = 1'b0;
        IFID_CLR   = 1'b1;
        IDEX_CLR   = 1'b1;
        EXMEM_CLR  = 1'b1;
        next_state = S_IDLE;
        inc_stall  = 1'b0;
        inc_flush  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) next_state = S_RUN;
            end
            S_RUN: begin
                next_state = S_RUN;
                EXMEM_CLR  = 1'b0;
                if (branch_taken) begin
                    PC_EN     = 1'b1;
                    IFID_EN   = 1'b1;
                    inc_flush = 1'b1;
                end else if (luh) begin
                    IFID_CLR  = 1'b0;
                    inc_stall = 1'b1;
                end else if (halt_req) begin
                    IFID_CLR   = 1'b0;
                    IDEX_CLR   = 1'b0;
                    next_state = S_HALT;
                end else begin
                    PC_EN    = 1'b1;
                    IFID_EN  = 1'b1;
                    IFID_CLR = 1'b0;
                    IDEX_CLR = 1'b0;
                end
            end
            S_HALT: begin
                EXMEM_CLR = 1'b0;
                if (resume) begin
                    next_state = S_RUN;
                end else begin
                    IFID_CLR   = 1'b0;
                    next_state = S_HALT;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
        if (RST) begin
            PC_EN     = 1'b0;
            IFID_EN   = 1'b0;
            IFID_CLR  = 1'b1;
            IDEX_CLR  = 1'b1;
            EXMEM_CLR = 1'b1;
        end
    end

    // State register and saturating event counters.
    always_ff @(posedge clk) begin
        if (RST) begin
            state     <= S_IDLE;
            cycle_cnt <= 32'd0;
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            state <= next_state;
            if (state == S_RUN) cycle_cnt <= cycle_cnt + 32'd1;
            if (inc_stall && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (inc_flush && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end

endmodule
